load_store_unit: RTL

Sits between the MIPS execute stage and the word-addressed data memory, converting byte, halfword and word loads/stores into whole-word accesses. Loads return sign- or zero-extended data; partial stores use a two-access read-modify-write. Misaligned and out-of-range requests are rejected with an error response and no memory access. The CPU stalls on `busy`.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU accesses into whole-word
// memory cycles, with read-modify-write for partial stores.
module load_store_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [31:0]           MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } lsuState_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    lsuState_t state;
    lsuState_t stateNext;

    logic                  weQ;
    logic [1:0]            sizeQ;
    logic                  unsQ;
    logic [31:0]           addrQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] mergeQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic                  errQ;

    logic                  accept;
    logic                  misaligned;
    logic                  outOfRange;
    logic                  reqErr;
    logic [31:0]           wordIdx;
    lsuState_t             acceptState;

    logic [4:0]            laneShift;
    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            laneByte;
    logic [15:0]           laneHalf;
    logic [DATA_WIDTH-1:0] loadVal;
    logic [DATA_WIDTH-1:0] mergeVal;
    logic                  isWordStoreQ;

    // Request decode, evaluated on the live inputs at the accepting edge
    assign wordIdx    = {2'b00, addr[31:2]};
    assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign outOfRange = wordIdx >= 32'(MEMORY_DEPTH);
    assign reqErr     = misaligned || outOfRange || (size == SZ_BAD);

    always_comb begin
        acceptState = RD;
        if (reqErr) begin
            acceptState = DONE;
        end else if (we && (size == SZ_WORD)) begin
            acceptState = WR;
        end
    end

    // A request held through DONE is taken on the edge that ends DONE,
    // so back-to-back accesses lose no cycle.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    stateNext = acceptState;
                end
            end
            RD: begin
                stateNext = weQ ? WR : DONE;
            end
            WR: begin
                stateNext = DONE;
            end
            DONE: begin
                if (req) begin
                    accept    = 1'b1;
                    stateNext = acceptState;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Lane extraction and merge, little-endian within the word
    assign laneShift = {addrQ[1:0], 3'b000};
    assign shifted   = MemReadData >> laneShift;
    assign laneByte  = shifted[7:0];
    assign laneHalf  = addrQ[1] ? MemReadData[31:16] : MemReadData[15:0];

    always_comb begin
        loadVal = MemReadData;
        unique case (sizeQ)
            SZ_BYTE: loadVal = {{24{~unsQ & laneByte[7]}}, laneByte};
            SZ_HALF: loadVal = {{16{~unsQ & laneHalf[15]}}, laneHalf};
            default: loadVal = MemReadData;
        endcase
    end

    always_comb begin
        mergeVal = MemReadData;
        unique case (sizeQ)
            SZ_BYTE: mergeVal[laneShift +: 8] = wdataQ[7:0];
            SZ_HALF: mergeVal[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
            default: mergeVal = MemReadData;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weQ    <= 1'b0;
            sizeQ  <= 2'b00;
            unsQ   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            errQ   <= 1'b0;
        end else if (accept) begin
            weQ    <= we;
            sizeQ  <= size;
            unsQ   <= unsigned_ld;
            addrQ  <= addr;
            wdataQ <= wdata;
            errQ   <= reqErr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdataQ <= '0;
            mergeQ <= '0;
        end else if (state == RD) begin
            if (weQ) begin
                mergeQ <= mergeVal;
            end else begin
                rdataQ <= loadVal;
            end
        end
    end

    assign isWordStoreQ = (sizeQ == SZ_WORD);

    // Memory-side outputs decode from state alone, so an asynchronous
    // reset withdraws the write strobe immediately.
    assign rdata        = rdataQ;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err          = (state == DONE) && errQ;
    assign MemRead      = (state == RD);
    assign MemWrite     = (state == WR);
    assign MemAddress   = ((state == RD) || (state == WR)) ?
                          {2'b00, addrQ[31:2]} : 32'd0;
    assign MemWriteData = (state == WR) ?
                          (isWordStoreQ ? wdataQ : mergeQ) : '0;

endmodule
